// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with freeze, wrap/saturate, sticky ovf.
// Define PERF_SNAPSHOT_EN to add the snap port and a shadow set for read-out.
module perf_counter_bank #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = 4,
    parameter int CH0_CYCLES = 1,
    parameter int SATURATE   = 0
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic              EN,
    input  logic              halt,
    input  logic              clr,
    input  logic [NUM_CH-1:0] ev,
`ifdef PERF_SNAPSHOT_EN
    input  logic              snap,
`endif
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] ovf,
    output logic              frozen
);

    typedef enum logic {
        ST_RUN,
        ST_FROZEN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  ovf_q, ovf_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic [NUM_CH-1:0]  inc;
    logic               count_en;
`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0]   shd_q [NUM_CH];
    logic [CNT_W-1:0]   shd_d [NUM_CH];
`endif

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN:    if (halt && EN) state_d = ST_FROZEN;
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    assign count_en = (state_q == ST_RUN) && EN && !clr;

    always_comb begin
        inc = ev;
        if (CH0_CYCLES != 0) inc[0] = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (count_en && inc[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    // Shadow captures the pre-increment live values on the snap edge
    always_comb begin
        shd_d = shd_q;
        if (clr) begin
            for (int i = 0; i < NUM_CH; i++) shd_d[i] = '0;
        end else if (snap) begin
            shd_d = cnt_q;
        end
    end
`endif

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
`ifdef PERF_SNAPSHOT_EN
                rd_d = shd_q[i];
`else
                rd_d = cnt_q[i];
`endif
            end
        end
    end

    always_ff @(posedge in_CLK or negedge in_RST) begin
        if (!in_RST) begin
            state_q <= ST_RUN;
            ovf_q   <= '0;
            rd_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
`ifdef PERF_SNAPSHOT_EN
                shd_q[i] <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
`ifdef PERF_SNAPSHOT_EN
                shd_q[i] <= shd_d[i];
`endif
            end
        end
    end

    assign rd_data = rd_q;
    assign ovf     = ovf_q;
    assign frozen  = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: directed table, corner sequences and
// randomized stimulus against a count-based reference model.
module tb_perf_counter_bank;

    logic        in_CLK;
    logic        in_RST;
    logic        EN;
    logic        halt;
    logic        clr;
    logic [3:0]  ev;
    logic [3:0]  rd_sel;
`ifdef PERF_SNAPSHOT_EN
    logic        snap;
`endif

    logic [31:0] rd32;
    logic [3:0]  rdw, rds;
    logic [3:0]  ovf32, ovfw, ovfs;
    logic        frz32, frzw, frzs;

    int n_tests = 0;
    int n_fail  = 0;

    perf_counter_bank dut32 (
        .in_CLK(in_CLK), .in_RST(in_RST), .EN(EN), .halt(halt), .clr(clr),
        .ev(ev),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_sel(rd_sel), .rd_data(rd32), .ovf(ovf32), .frozen(frz32)
    );

    perf_counter_bank #(.CNT_W(4), .SATURATE(0)) dutw (
        .in_CLK(in_CLK), .in_RST(in_RST), .EN(EN), .halt(halt), .clr(clr),
        .ev(ev),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_sel(rd_sel), .rd_data(rdw), .ovf(ovfw), .frozen(frzw)
    );

    perf_counter_bank #(.CNT_W(4), .SATURATE(1)) duts (
        .in_CLK(in_CLK), .in_RST(in_RST), .EN(EN), .halt(halt), .clr(clr),
        .ev(ev),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_sel(rd_sel), .rd_data(rds), .ovf(ovfs), .frozen(frzs)
    );

    initial in_CLK = 1'b0;
    always #5 in_CLK = ~in_CLK;

    // Model: true (unbounded) event counts; every DUT view derives from them
    longint unsigned cnt_m [4];
    longint unsigned shd_m [4];
    logic            frz_m;
    logic [31:0]     e_rd32;
    logic [3:0]      e_rdw, e_rds;

    function automatic logic [3:0] wrap4(longint unsigned c);
        return 4'(c % 16);
    endfunction

    function automatic logic [3:0] sat4(longint unsigned c);
        return (c > 15) ? 4'd15 : 4'(c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            cnt_m[i] = 0;
            shd_m[i] = 0;
        end
        frz_m  = 1'b0;
        e_rd32 = '0;
        e_rdw  = '0;
        e_rds  = '0;
    endtask

    task automatic model_edge(input logic en, input logic h, input logic c,
                              input logic [3:0] e, input logic [3:0] sel,
                              input logic sn);
        int s;
        longint unsigned src;
        s   = int'(sel);
        src = 0;
        if (s < 4) begin
`ifdef PERF_SNAPSHOT_EN
            src = shd_m[s];
`else
            src = cnt_m[s];
`endif
        end
        e_rd32 = (s < 4) ? 32'(src) : 32'd0;
        e_rdw  = (s < 4) ? wrap4(src) : 4'd0;
        e_rds  = (s < 4) ? sat4(src) : 4'd0;
        if (c) begin
            for (int i = 0; i < 4; i++) begin
                cnt_m[i] = 0;
                shd_m[i] = 0;
            end
            frz_m = 1'b0;
        end else begin
            if (sn) shd_m = cnt_m;
            if (en && !frz_m) begin
                cnt_m[0]++;
                for (int i = 1; i < 4; i++) if (e[i]) cnt_m[i]++;
                if (h) frz_m = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] ow, o32;
        for (int i = 0; i < 4; i++) begin
            ow[i]  = cnt_m[i] > 15;
            o32[i] = cnt_m[i] > 64'hFFFF_FFFF;
        end
        chk("rd32", rd32, e_rd32);
        chk("rd_wrap", {28'd0, rdw}, {28'd0, e_rdw});
        chk("rd_sat", {28'd0, rds}, {28'd0, e_rds});
        chk("ovf32", {28'd0, ovf32}, {28'd0, o32});
        chk("ovf_wrap", {28'd0, ovfw}, {28'd0, ow});
        chk("ovf_sat", {28'd0, ovfs}, {28'd0, ow});
        chk("frozen32", {31'd0, frz32}, {31'd0, frz_m});
        chk("frozen_w", {31'd0, frzw}, {31'd0, frz_m});
        chk("frozen_s", {31'd0, frzs}, {31'd0, frz_m});
    endtask

    task automatic step(input logic en, input logic h, input logic c,
                        input logic [3:0] e, input logic [3:0] sel,
                        input logic sn);
        EN     = en;
        halt   = h;
        clr    = c;
        ev     = e;
        rd_sel = sel;
`ifdef PERF_SNAPSHOT_EN
        snap   = sn;
`endif
        @(posedge in_CLK);
        model_edge(en, h, c, e, sel, sn);
        #1;
        check_all();
    endtask

    typedef struct {
        logic        en;
        logic        h;
        logic        c;
        logic [3:0]  e;
        logic [3:0]  sel;
        logic [31:0] rd;
        logic        frz;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic h, input logic c,
                       input logic [3:0] e, input logic [3:0] sel,
                       input logic [31:0] rd, input logic frz);
        vec_t v;
        v = '{en, h, c, e, sel, rd, frz};
        tbl.push_back(v);
    endtask

    initial begin
        in_RST = 1'b0;
        EN     = 1'b0;
        halt   = 1'b0;
        clr    = 1'b0;
        ev     = '0;
        rd_sel = '0;
`ifdef PERF_SNAPSHOT_EN
        snap   = 1'b0;
`endif
        model_reset();

        // rd_data after each edge shows the 32-bit channel before that edge
        for (int i = 0; i < 10; i++) add(1, 0, 0, 4'h0, 4'd0, i, 0);
        add(0, 0, 0, 4'h0, 4'd0, 10, 0);
        add(0, 0, 0, 4'h0, 4'd1, 0, 0);
        add(0, 0, 0, 4'h0, 4'd3, 0, 0);
        add(1, 0, 0, 4'h4, 4'd2, 0, 0);
        add(0, 0, 0, 4'h4, 4'd2, 1, 0);
        add(1, 0, 0, 4'h4, 4'd2, 1, 0);
        add(0, 0, 0, 4'h4, 4'd2, 2, 0);
        add(1, 0, 0, 4'h4, 4'd0, 12, 0);
        add(0, 0, 0, 4'h0, 4'd2, 3, 0);
        add(0, 0, 0, 4'h0, 4'd0, 13, 0);
        add(1, 1, 0, 4'h2, 4'd1, 0, 1);
        add(1, 0, 0, 4'h2, 4'd1, 1, 1);
        add(1, 0, 0, 4'hF, 4'd0, 14, 1);
        add(1, 1, 1, 4'hF, 4'd0, 14, 0);
        add(0, 0, 0, 4'h0, 4'd0, 0, 0);
        add(0, 0, 0, 4'h0, 4'd1, 0, 0);
        add(0, 0, 0, 4'h0, 4'd7, 0, 0);

        repeat (3) @(posedge in_CLK);
        #1;
        check_all();
        in_RST = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].en, tbl[k].h, tbl[k].c, tbl[k].e, tbl[k].sel, 1'b0);
`ifndef PERF_SNAPSHOT_EN
            chk($sformatf("tbl_rd[%0d]", k), rd32, tbl[k].rd);
`endif
            chk($sformatf("tbl_frz[%0d]", k), {31'd0, frz32},
                {31'd0, tbl[k].frz});
        end

        // Halt with coincident event, then 20 events while frozen
        step(1, 1, 0, 4'h2, 4'd1, 0);
        chk("halt_frozen", {31'd0, frz32}, 32'd1);
        repeat (20) step(1, 0, 0, 4'h2, 4'd1, 0);
        step(0, 0, 0, 4'h0, 4'd1, 0);
`ifndef PERF_SNAPSHOT_EN
        chk("frozen_ch1", rd32, 32'd1);
`endif
        step(0, 0, 1, 4'h0, 4'd0, 0);
        chk("clr_unfreeze", {31'd0, frz32}, 32'd0);
        for (int s = 0; s < 4; s++) step(0, 0, 0, 4'h0, 4'(s), 0);
        step(0, 0, 0, 4'h0, 4'd0, 0);
        chk("clr_ch3", rd32, 32'd0);

        // Wrap versus saturate on 4-bit channels
        repeat (17) step(1, 0, 0, 4'h8, 4'd3, 0);
        step(0, 0, 0, 4'h0, 4'd3, 0);
`ifndef PERF_SNAPSHOT_EN
        chk("wrap_ch3", {28'd0, rdw}, 32'd1);
        chk("sat_ch3", {28'd0, rds}, 32'd15);
`endif
        chk("wrap_ovf3", {31'd0, ovfw[3]}, 32'd1);
        chk("sat_ovf3", {31'd0, ovfs[3]}, 32'd1);
        step(0, 0, 1, 4'h0, 4'd0, 0);

`ifdef PERF_SNAPSHOT_EN
        repeat (50) step(1, 0, 0, 4'h0, 4'd0, 0);
        step(0, 0, 0, 4'h0, 4'd0, 1);
        repeat (30) step(1, 0, 0, 4'h0, 4'd0, 0);
        chk("snap_hold", rd32, 32'd50);
        step(0, 0, 0, 4'h0, 4'd0, 1);
        step(0, 0, 0, 4'h0, 4'd0, 0);
        chk("snap_new", rd32, 32'd80);
`endif

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2;
                in_RST = 1'b0;
                #1;
                model_reset();
                check_all();
                @(posedge in_CLK);
                #1;
                check_all();
                #2;
                in_RST = 1'b1;
            end
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 39) == 0,
                 4'($urandom),
                 4'($urandom_range(0, 7)),
                 $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised performance-counter bank for the 5-stage pipeline; successor to the fixed four-counter unit.
- Counts total cycles, jumps, taken branches and load-use stalls, plus any further event lines, across NUM_CH channels of configurable width.
- Supports freeze on halt, wrap or saturate mode, sticky overflow flags and a registered read-out port that feeds the display data mux.

Parameters:
- NUM_CH, 4, number of counter channels (2..16).
- CNT_W, 32, width of each counter in bits.
- SEL_W, 4, width of rd_sel; must satisfy 2^SEL_W >= NUM_CH.
- CH0_CYCLES, 1, when 1, channel 0 counts every enabled cycle and ignores ev[0].
- SATURATE, 0, 0 = counters wrap to 0; 1 = counters stick at all-ones.

Ports:
- in_CLK  in  1  pipeline clock.
- in_RST  in  1  asynchronous reset, active-low.
- EN  in  1  pipeline enable; counting happens only when EN=1.
- halt  in  1  syscall-halt pulse; freezes the bank.
- clr  in  1  synchronous clear of counters, overflow flags and freeze.
- ev  in  NUM_CH  per-channel event strobes, each sampled as +1 per cycle.
- rd_sel  in  SEL_W  channel select for read-out.
- rd_data  out  CNT_W  registered value of the selected channel.
- ovf  out  NUM_CH  sticky per-channel overflow flags.
- frozen  out  1  high while the bank is frozen.

Behaviour:
- Reset (in_RST=0, asynchronous):
  - all counters, ovf, frozen and rd_data go to 0 immediately.
  - these values are held for as long as in_RST=0.
- State machine, frozen bit:
  - RUN → FROZEN on a clock edge where halt=1 and EN=1.
  - FROZEN → RUN only on clr=1 or on reset.
  - halt=1 while already FROZEN has no effect.
- Increment rule, channel i, RUN state, EN=1, clr=0:
  - with CH0_CYCLES=1, channel 0 increments every such cycle; ev[0] is ignored.
  - every other channel increments when ev[i]=1.
  - halt in the same cycle as an event: that event is still counted; freeze takes effect from the next edge.
- No counting when EN=0 or FROZEN:
  - all counters hold.
  - the ev lines are ignored; they are not accumulated.
- Width and overflow rules:
  - an increment from all-ones sets ovf[i]=1.
  - SATURATE=0: the counter becomes 0.
  - SATURATE=1: the counter stays at all-ones.
  - ovf[i] stays 1 until clr or reset.
- clr=1:
  - on the next edge, all counters, ovf and frozen go to 0.
  - clr has priority over events, halt and EN; events in that cycle are lost.
  - halt=1 together with clr=1 gives frozen=0.
- Read-out:
  - rd_data updates on every edge, regardless of EN or frozen, with the channel value as it was before that edge's update.
  - latency is 1 cycle from rd_sel.
  - rd_sel >= NUM_CH gives rd_data=0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- When defined:
  - adds input port snap (1 bit) and a shadow register set of NUM_CH×CNT_W.
  - snap=1 copies all live counters into the shadow set on the same edge, atomically.
  - when snap and an increment occur in the same cycle, the shadow captures the pre-increment value.
  - rd_data reads the shadow set instead of the live counters.
  - clr and reset also zero the shadow set.
- When not defined:
  - no snap port and no shadow storage.
  - rd_data reads the live counters.

Test Plan:
- Reset behaviour: hold in_RST=0 for 3 cycles, release, EN=1 for 10 cycles, ev=0, rd_sel=0 → rd_data=10 on the cycle after the 10th edge; channels 1..3 read 0; ovf=0.
- Event counting: EN=1, pulse ev[2] on 5 cycles, with 2 of those cycles at EN=0 → channel 2 reads 3; channel 0 counts only the EN=1 cycles.
- Halt freeze: halt=1 together with ev[1]=1 → channel 1 increments once; frozen=1 from the next cycle; 20 further ev[1] pulses leave it unchanged; clr=1 → every channel reads 0 and frozen=0.
- Wrap versus saturate: CNT_W=4, SATURATE=0, 17 ev[3] pulses → channel 3 reads 1 and ovf[3]=1. Repeat with SATURATE=1 → channel 3 reads 15 and ovf[3]=1.
- clr priority and select range: clr=1 together with ev=4'b1111 and halt=1 → all channels 0, frozen=0. Then rd_sel=7 with NUM_CH=4 → rd_data=0.
- Snapshot (PERF_SNAPSHOT_EN defined): run channel 0 to 50, pulse snap, run 30 more cycles → rd_data(sel 0) stays 50 until the next snap, then reads 80.
